// File: rtl/div_bus_sched.sv
// Round-robin bus master that shares one memory-mapped divider between two requesters.
// Optional poll timeout: define DIV_SCHED_TIMEOUT_EN.
module div_bus_sched #(
    parameter int DW = 16,
    parameter int AW = 4,
    parameter logic [AW-1:0] ADDR_A    = 'h0,
    parameter logic [AW-1:0] ADDR_B    = 'h2,
    parameter logic [AW-1:0] ADDR_INIT = 'h4,
    parameter logic [AW-1:0] ADDR_RES  = 'h6,
    parameter logic [AW-1:0] ADDR_DONE = 'h8
`ifdef DIV_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    input  logic          req1,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] result,
    output logic          err,
    output logic          busy,
    output logic          cs,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic [DW-1:0] bus_dout,
    input  logic [DW-1:0] bus_din,
    output logic [3:0]    dbg_state
);

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_GO, WR_STOP, POLL_RD, POLL_CHK, RES_RD, RES_CAP, ACK
    } state_t;

    state_t        state;
    logic          last_gnt;
    logic          pick;
    logic [DW-1:0] op_b;
    logic [DW-1:0] pick_a;
    logic [DW-1:0] pick_b;
`ifdef DIV_SCHED_TIMEOUT_EN
    logic [7:0]    poll_cnt;
`endif

    // Valid/ready style: a request is a level held until its ack pulse; the ack is the only completion handshake.
    always_comb begin
        pick = req1;
        if (req0 && req1) pick = ~last_gnt;
    end

    assign pick_a    = pick ? a1 : a0;
    assign pick_b    = pick ? b1 : b0;
    assign dbg_state = state;

    // Bus strobes are registered on entry to each bus state, so each access lasts exactly that state's cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            op_b     <= '0;
            cs       <= 1'b0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            addr     <= '0;
            bus_dout <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            result   <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
            poll_cnt <= '0;
`endif
        end else begin
            cs   <= 1'b0;
            rd   <= 1'b0;
            wr   <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        last_gnt <= pick;
                        op_b     <= pick_b;
                        busy     <= 1'b1;
                        if (pick_b == '0) begin
                            result <= '1;
                            err    <= 1'b1;
                            state  <= ACK;
                        end else begin
                            cs       <= 1'b1;
                            wr       <= 1'b1;
                            addr     <= ADDR_A;
                            bus_dout <= pick_a;
                            state    <= WR_A;
                        end
                    end
                end
                WR_A: begin
                    cs       <= 1'b1;
                    wr       <= 1'b1;
                    addr     <= ADDR_B;
                    bus_dout <= op_b;
                    state    <= WR_B;
                end
                WR_B: begin
                    cs       <= 1'b1;
                    wr       <= 1'b1;
                    addr     <= ADDR_INIT;
                    bus_dout <= DW'(1);
                    state    <= WR_GO;
                end
                WR_GO: begin
                    cs       <= 1'b1;
                    wr       <= 1'b1;
                    addr     <= ADDR_INIT;
                    bus_dout <= '0;
                    state    <= WR_STOP;
                end
                WR_STOP: begin
                    cs    <= 1'b1;
                    rd    <= 1'b1;
                    addr  <= ADDR_DONE;
                    state <= POLL_RD;
`ifdef DIV_SCHED_TIMEOUT_EN
                    poll_cnt <= '0;
`endif
                end
                POLL_RD: state <= POLL_CHK;
                POLL_CHK: begin
                    if (bus_din[0]) begin
                        cs    <= 1'b1;
                        rd    <= 1'b1;
                        addr  <= ADDR_RES;
                        state <= RES_RD;
`ifdef DIV_SCHED_TIMEOUT_EN
                    end else if (poll_cnt == 8'(TIMEOUT_CYC - 1)) begin
                        result <= '1;
                        err    <= 1'b1;
                        state  <= ACK;
`endif
                    end else begin
`ifdef DIV_SCHED_TIMEOUT_EN
                        poll_cnt <= poll_cnt + 8'd1;
`endif
                        cs    <= 1'b1;
                        rd    <= 1'b1;
                        addr  <= ADDR_DONE;
                        state <= POLL_RD;
                    end
                end
                RES_RD: state <= RES_CAP;
                RES_CAP: begin
                    result <= bus_din;
                    err    <= 1'b0;
                    state  <= ACK;
                end
                ACK: begin
                    ack0  <= ~last_gnt;
                    ack1  <= last_gnt;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_bus_sched.sv
// Randomized bench for div_bus_sched with a behavioural divider peripheral and a transaction-level reference model.
module tb_div_bus_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        ack0, ack1, err, busy, cs, rd, wr;
    logic [15:0] result, bus_dout, bus_din;
    logic [3:0]  addr;
    logic [3:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    div_bus_sched #(
        .DW(16), .AW(4)
`ifdef DIV_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYC(4)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .result(result), .err(err), .busy(busy),
        .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .bus_dout(bus_dout), .bus_din(bus_din), .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Divider peripheral: quotient fixed at init, done reads 0 for p_cfg_polls reads, then 1
    int          p_cfg_polls = 0;
    int          p_polls_left = 0;
    logic [15:0] p_a = '0, p_b = '0, p_q = '0;
    initial bus_din = '0;

    always @(posedge clk) begin
        if (cs && wr) begin
            case (addr)
                4'h0: p_a <= bus_dout;
                4'h2: p_b <= bus_dout;
                4'h4: if (bus_dout[0]) begin
                    p_q <= (p_b == 0) ? 16'hFFFF : p_a / p_b;
                    p_polls_left <= p_cfg_polls;
                end
                default: ;
            endcase
        end
        if (cs && rd) begin
            case (addr)
                4'h8: if (p_polls_left > 0) begin
                    bus_din <= 16'h0;
                    p_polls_left <= p_polls_left - 1;
                end else begin
                    bus_din <= 16'h1;
                end
                4'h6: bus_din <= p_q;
                default: bus_din <= 16'h0;
            endcase
        end
    end

    // Bus log of every chip-selected cycle: {wr, rd, addr, write data}
    logic [21:0] bus_log[$];
    logic [21:0] exp_q[$];

    always @(posedge clk) if (cs) bus_log.push_back({wr, rd, addr, wr ? bus_dout : 16'h0});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: bus accesses a transaction must produce
    task automatic expect_bus(input logic [15:0] a, input logic [15:0] b, input int npoll, input bit timeout);
        if (b == 0) return;
        exp_q.push_back({2'b10, 4'h0, a});
        exp_q.push_back({2'b10, 4'h2, b});
        exp_q.push_back({2'b10, 4'h4, 16'h1});
        exp_q.push_back({2'b10, 4'h4, 16'h0});
        for (int i = 0; i < npoll + (timeout ? 0 : 1); i++) exp_q.push_back({2'b01, 4'h8, 16'h0});
        if (!timeout) exp_q.push_back({2'b01, 4'h6, 16'h0});
    endtask

    function automatic logic [15:0] ref_quot(input logic [15:0] a, input logic [15:0] b);
        return (b == 0) ? 16'hFFFF : a / b;
    endfunction

    function automatic int ref_lat(input logic [15:0] b, input int npoll);
        return (b == 0) ? 1 : 9 + 2 * npoll;
    endfunction

    task automatic check_bus(input string tag);
        check({tag, "_bus_len"}, bus_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++)
            check({tag, "_bus_acc"}, {10'h0, bus_log[i]}, {10'h0, exp_q[i]});
        bus_log.delete();
        exp_q.delete();
    endtask

    // Waits for an ack on port; latency counted in edges from the first edge after the call
    task automatic wait_ack(input int port, input logic [15:0] exp_res, input logic exp_err,
                            input int exp_lat, input string tag);
        bit seen = 0;
        bit wrong = 0;
        int lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (port == 0 ? ack1 : ack0) wrong = 1;
            if (port == 0 ? ack0 : ack1) begin
                seen = 1;
                lat = i - 1;
                break;
            end
        end
        check({tag, "_ack_seen"}, seen, 1);
        check({tag, "_other_ack"}, wrong, 0);
        if (seen) begin
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_result"}, result, exp_res);
            check({tag, "_err"}, err, exp_err);
        end
    endtask

    // Driver: one transaction from one requester, requester drops req in its ack cycle
    task automatic run_single(input int port, input logic [15:0] a, input logic [15:0] b,
                              input int npoll, input string tag);
        p_cfg_polls = npoll;
        expect_bus(a, b, npoll, 0);
        if (port == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
        else begin a1 = a; b1 = b; req1 = 1'b1; end
        wait_ack(port, ref_quot(a, b), b == 0, ref_lat(b, npoll), tag);
        req0 = 1'b0;
        req1 = 1'b0;
        check_bus(tag);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 0);
        check("rst_rd_wr", {rd, wr}, 0);
        check("rst_acks", {ack0, ack1}, 0);
        check("rst_err_busy", {err, busy}, 0);
        check("rst_addr", addr, 0);
        check("rst_dout", bus_dout, 0);
        check("rst_result", result, 0);
        rst = 1'b1;
        @(negedge clk);

        run_single(0, 16'd35, 16'd5, 0, "basic");
        check("idle_busy", busy, 0);

        run_single(1, 16'd1234, 16'd0, 0, "divzero");

        // Simultaneous requests: req0 wins the tie after a req1 grant
        p_cfg_polls = 0;
        expect_bus(16'd10, 16'd4, 0, 0);
        expect_bus(16'd100, 16'd10, 0, 0);
        a0 = 10; b0 = 4; a1 = 100; b1 = 10; req0 = 1; req1 = 1;
        wait_ack(0, 16'd2, 0, 9, "pair0");
        req0 = 0;
        wait_ack(1, 16'd10, 0, 9, "pair1");
        req1 = 0;
        check_bus("pair");
        @(negedge clk);

        // req0 keeps requesting: pending req1 must be served in between
        expect_bus(16'd50, 16'd7, 0, 0);
        expect_bus(16'd81, 16'd9, 0, 0);
        expect_bus(16'd300, 16'd20, 0, 0);
        a0 = 50; b0 = 7; a1 = 81; b1 = 9; req0 = 1; req1 = 1;
        wait_ack(0, 16'd7, 0, 9, "rr0");
        a0 = 300; b0 = 20;
        wait_ack(1, 16'd9, 0, 9, "rr1");
        req1 = 0;
        wait_ack(0, 16'd15, 0, 9, "rr2");
        req0 = 0;
        check_bus("rr");
        @(negedge clk);

        run_single(0, 16'd35, 16'd5, 3, "slow_done");

        // Reset while polling
        begin
            bit hit = 0;
            p_cfg_polls = 2;
            a0 = 90; b0 = 9; req0 = 1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (cs && rd && addr == 4'h8) begin hit = 1; break; end
            end
            check("rst_mid_reached_poll", hit, 1);
            rst = 1'b0;
            #1;
            check("rst_mid_strobes", {cs, rd, wr}, 0);
            check("rst_mid_busy", busy, 0);
            req0 = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("rst_mid_no_ack", {ack0, ack1}, 0);
            end
            rst = 1'b1;
            @(negedge clk);
            bus_log.delete();
            exp_q.delete();
            run_single(0, 16'd90, 16'd9, 0, "after_rst");
        end

        for (int n = 0; n < 8; n++) begin
            int port = $urandom_range(0, 1);
            logic [15:0] a = 16'($urandom_range(0, 65535));
            logic [15:0] b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 300));
            run_single(port, a, b, $urandom_range(0, 3), "rand");
        end

`ifdef DIV_SCHED_TIMEOUT_EN
        p_cfg_polls = 1000;
        expect_bus(16'd10, 16'd3, 4, 1);
        a0 = 10; b0 = 3; req0 = 1;
        wait_ack(0, 16'hFFFF, 1, 13, "timeout");
        req0 = 0;
        check_bus("timeout");
        p_cfg_polls = 0;
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
